// File: rtl/rr_mux_sel_arbiter.sv
// rtl/rr_mux_sel_arbiter.sv - round-robin arbiter driving a 4:1 mux select
// Optional: define RR_LOCK_EN to add the lock input that suspends the hold limit.
module rr_mux_sel_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
`ifdef RR_LOCK_EN
    input  logic       lock,
`endif
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       valid
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    logic [1:0]       r_sel;
    logic [3:0]       r_grant;
    logic             r_valid;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [1:0]       r_last;

    state_t           w_state_nxt;
    logic [1:0]       w_sel_nxt;
    logic [3:0]       w_grant_nxt;
    logic             w_valid_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_last_nxt;

    logic [1:0]       w_win;
    logic [1:0]       w_idx;
    logic             w_found;
    logic             w_any;
    logic             w_at_limit;
    logic             w_lock_hold;
    logic             w_release;

    // Scan starts just after the last winner, so it gets lowest priority.
    always_comb begin
        w_win   = r_last;
        w_idx   = r_last;
        w_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_any      = |req;
    assign w_at_limit = (r_hold_cnt == HOLD_LAST);

`ifdef RR_LOCK_EN
    assign w_lock_hold = lock && req[r_sel];
`else
    assign w_lock_hold = 1'b0;
`endif

    assign w_release = !req[r_sel] || (w_at_limit && !w_lock_hold);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 2'b00;
            r_grant    <= 4'b0000;
            r_valid    <= 1'b0;
            r_hold_cnt <= '0;
            r_last     <= 2'b11;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_grant    <= w_grant_nxt;
            r_valid    <= w_valid_nxt;
            r_hold_cnt <= w_cnt_nxt;
            r_last     <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_grant_nxt = r_grant;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = r_hold_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                    w_sel_nxt   = w_win;
                    w_grant_nxt = 4'b0001 << w_win;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = w_win;
                end
            end
            S_GRANT: begin
                if (w_release && w_any) begin
                    w_sel_nxt   = w_win;
                    w_grant_nxt = 4'b0001 << w_win;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = w_win;
                end else if (w_release) begin
                    // sel is left alone so the mux output stays stable while idle
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = 4'b0000;
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (!w_at_limit) begin
                    w_cnt_nxt   = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 4'b0000;
                w_valid_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        sel   = r_sel;
        grant = r_grant;
        valid = r_valid;
    end

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// tb/tb_rr_mux_sel_arbiter.sv - directed self-checking bench for rr_mux_sel_arbiter
module tb_rr_mux_sel_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_a, req_b, req_c;
    logic       lock_c;
    logic [1:0] sel_a, sel_b, sel_c;
    logic [3:0] grant_a, grant_b, grant_c;
    logic       valid_a, valid_b, valid_c;

    int n_checks;
    int n_fail;

    rr_mux_sel_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .req   (req_a),
`ifdef RR_LOCK_EN
        .lock  (1'b0),
`endif
        .sel   (sel_a),
        .grant (grant_a),
        .valid (valid_a)
    );

    rr_mux_sel_arbiter #(.MAX_HOLD(1), .CNT_W(8)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .req   (req_b),
`ifdef RR_LOCK_EN
        .lock  (1'b0),
`endif
        .sel   (sel_b),
        .grant (grant_b),
        .valid (valid_b)
    );

    rr_mux_sel_arbiter #(.MAX_HOLD(2), .CNT_W(8)) u_dut_c (
        .clk   (clk),
        .rst   (rst),
        .req   (req_c),
`ifdef RR_LOCK_EN
        .lock  (lock_c),
`endif
        .sel   (sel_c),
        .grant (grant_c),
        .valid (valid_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req_a  = 4'b0000;
        req_b  = 4'b0000;
        req_c  = 4'b0000;
        lock_c = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic [1:0] exp_sel, input logic exp_valid);
        chk({tag, "_sel"},   8'(sel_a),   8'(exp_sel));
        chk({tag, "_valid"}, 8'(valid_a), 8'(exp_valid));
        chk({tag, "_grant"}, 8'(grant_a), exp_valid ? 8'(4'b0001 << exp_sel) : 8'h00);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // reset state and one-cycle latency
        do_reset();
        chk_a("rst", 2'd0, 1'b0);
        req_a = 4'b0001;
        tick();
        chk_a("first", 2'd0, 1'b1);

        // fairness: each channel for exactly MAX_HOLD=4 cycles
        do_reset();
        req_a = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk_a($sformatf("fair%0d", k), 2'((k / 4) % 4), 1'b1);
        end

        // early release, sel held while idle
        do_reset();
        req_a = 4'b0100;
        tick();
        chk_a("early0", 2'd2, 1'b1);
        tick();
        chk_a("early1", 2'd2, 1'b1);
        req_a = 4'b0000;
        tick();
        chk_a("early_idle", 2'd2, 1'b0);
        tick();
        chk_a("early_idle2", 2'd2, 1'b0);

        // wrap priority: ch1 released at limit, ch0 next, then ch1 again
        do_reset();
        req_a = 4'b0010;
        tick();
        chk_a("wrap_g1", 2'd1, 1'b1);
        req_a = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_a($sformatf("wrap%0d", k), (k < 3) ? 2'd1 : ((k < 7) ? 2'd0 : 2'd1), 1'b1);
        end

        // reset mid-grant
        do_reset();
        req_a = 4'b0100;
        tick();
        chk_a("mid_g", 2'd2, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_a("mid_rst", 2'd0, 1'b0);
        req_a = 4'b1001;
        tick();
        chk_a("mid_1001", 2'd0, 1'b1);
        req_a = 4'b1000;
        tick();
        chk_a("mid_1000", 2'd3, 1'b1);

        // MAX_HOLD=1: rotate every cycle
        do_reset();
        req_b = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("h1_sel%0d", k), 8'(sel_b), 8'(k % 4));
            chk($sformatf("h1_grant%0d", k), 8'(grant_b), 8'(4'b0001 << (k % 4)));
        end
        chk("h1_valid", 8'(valid_b), 8'd1);

        // MAX_HOLD=2 limit applies without lock
        do_reset();
        req_c = 4'b0011;
        tick();
        chk("c_g0", 8'(sel_c), 8'd0);
        tick();
        chk("c_g0b", 8'(sel_c), 8'd0);
        tick();
        chk("c_g1", 8'(sel_c), 8'd1);

`ifdef RR_LOCK_EN
        // lock holds ch0 for 6 cycles, then hold limit releases it
        do_reset();
        req_c = 4'b0011;
        tick();
        chk("lk_g0", 8'(sel_c), 8'd0);
        lock_c = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("lk_hold%0d", k), 8'(grant_c), 8'h01);
        end
        lock_c = 1'b0;
        tick();
        chk("lk_rel_sel", 8'(sel_c), 8'd1);
        chk("lk_rel_valid", 8'(valid_c), 8'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
